sr_bank_arbiter: RTL

Round-robin arbiter and sequencer for a shared bank of NBITS set/reset storage bits. Up to NREQ requesters issue set or clear commands against individual bits. The block serialises them and drives one-hot S/R pulses that never assert S and R on the same bit. It keeps the bank's current value on `q`. It sits in front of the master-slave SR bank, so that no requester ever drives that bank directly.

---
 rtl/sr_bank_arbiter_if.sv | 36 +++
 rtl/sr_bank_arbiter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/sr_bank_arbiter_if.sv
// Command/pulse bundle between the requesters and the SR bank arbiter.
//   req   : per-requester command request (level)
//   op    : per-requester opcode, 1 = set, 0 = clear
//   idx   : per-requester target bit, requester i at idx[i*IDXW +: IDXW]
//   gnt   : one-hot, one-cycle grant pulse
//   s_out : set pulses to the SR bank
//   r_out : reset pulses to the SR bank
//   q     : shadow copy of the bank contents
//   busy  : arbiter is in DRIVE or SETTLE
//   err   : granted command carried an out-of-range index
// The requester side uses the master modport, the arbiter the slave modport.
interface sr_bank_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int NBITS = 8,
    parameter int IDXW  = 3
);
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      op;
    logic [NREQ*IDXW-1:0] idx;
    logic [NREQ-1:0]      gnt;
    logic [NBITS-1:0]     s_out;
    logic [NBITS-1:0]     r_out;
    logic [NBITS-1:0]     q;
    logic                 busy;
    logic                 err;

    modport master (
        output req, op, idx,
        input  gnt, s_out, r_out, q, busy, err
    );

    modport slave (
        input  req, op, idx,
        output gnt, s_out, r_out, q, busy, err
    );
endinterface

// File: rtl/sr_bank_arbiter.sv
// Round-robin arbiter and sequencer for a bank of NBITS set/reset bits.
// Serialises set/clear commands from NREQ requesters into one-hot S/R
// pulses (never S and R together) and keeps a shadow of the bank on q.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset
//   bus : sr_bank_arbiter_if slave modport (req/op/idx in; gnt, s_out,
//         r_out, q, busy, err out; all outputs registered)
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | sample req, pick winner from ptr upward, latch its op/idx
// DRIVE  | gnt and the S or R pulse (or err) are high for this one cycle
// SETTLE | outputs quiet; q and ptr updated at the end of this cycle
module sr_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int NBITS = 8,
    parameter int IDXW  = 3
) (
    input logic              clk,
    input logic              rst,
    sr_bank_arbiter_if.slave bus
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SETTLE
    } state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   win;
    logic            op_l;
    logic [IDXW-1:0] idx_l;
    logic            inr_l;

    logic            found;
    logic [PW-1:0]   win_c;
    logic [PW-1:0]   cand;
    logic            sel_op;
    logic [IDXW-1:0] sel_idx;
    logic            sel_inr;

    // Rotating priority search: first requester with req high, starting at ptr.
    always_comb begin
        found = 1'b0;
        win_c = '0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = PW'((int'(ptr) + k) % NREQ);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                win_c = cand;
            end
        end
        sel_op  = bus.op[win_c];
        sel_idx = bus.idx[win_c*IDXW +: IDXW];
        sel_inr = (int'(sel_idx) < NBITS);
    end

    // DRIVE-cycle outputs are computed on the IDLE->DRIVE edge so that they
    // come straight out of flops and line up with gnt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            win       <= '0;
            op_l      <= 1'b0;
            idx_l     <= '0;
            inr_l     <= 1'b0;
            bus.gnt   <= '0;
            bus.s_out <= '0;
            bus.r_out <= '0;
            bus.q     <= '0;
            bus.busy  <= 1'b0;
            bus.err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.gnt   <= '0;
                    bus.s_out <= '0;
                    bus.r_out <= '0;
                    bus.err   <= 1'b0;
                    bus.busy  <= 1'b0;
                    if (found) begin
                        state    <= DRIVE;
                        win      <= win_c;
                        op_l     <= sel_op;
                        idx_l    <= sel_idx;
                        inr_l    <= sel_inr;
                        bus.gnt  <= NREQ'(1) << win_c;
                        bus.busy <= 1'b1;
                        bus.err  <= !sel_inr;
                        if (sel_inr) begin
                            if (sel_op) bus.s_out <= NBITS'(1) << sel_idx;
                            else        bus.r_out <= NBITS'(1) << sel_idx;
                        end
                    end
                end
                DRIVE: begin
                    state     <= SETTLE;
                    bus.gnt   <= '0;
                    bus.s_out <= '0;
                    bus.r_out <= '0;
                    bus.err   <= 1'b0;
                    bus.busy  <= 1'b1;
                end
                SETTLE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    if (inr_l) bus.q[idx_l] <= op_l;
                    ptr <= (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
                end
                default: begin
                    state     <= IDLE;
                    bus.gnt   <= '0;
                    bus.s_out <= '0;
                    bus.r_out <= '0;
                    bus.err   <= 1'b0;
                    bus.busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
